arbitro_memoria: RTL and testbench
==================================

Name: arbitro_memoria

Overview:
- Shares the single-port 32x14 `memoria` between two requesters: port 0 is instruction fetch (read-only), port 1 is the load/store data port (read or write).
- Serialises accesses through a 3-state FSM and arbitrates round-robin when both ports request.
- Owns all memoria control pins (add, en, data_in) and returns data_out to the winning port with a one-cycle ack pulse.
- Sits between the control unit/datapath and memoria in the ISA top level.

Parameters:
- ADDR_W, 5, memory address width (32 words)
- DATA_W, 14, memory word width

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  reset, asynchronous, active-high
- req0  in  1  port 0 read request; held high until ack0
- add0  in  ADDR_W  port 0 address; stable while req0 high
- ack0  out  1  one-cycle pulse: port 0 transaction done, rdata0 valid
- rdata0  out  DATA_W  port 0 read data, held until next port 0 ack
- req1  in  1  port 1 request; held high until ack1
- we1  in  1  port 1: 1 = write, 0 = read; stable while req1 high
- add1  in  ADDR_W  port 1 address
- wdata1  in  DATA_W  port 1 write data
- ack1  out  1  one-cycle pulse: port 1 transaction done
- rdata1  out  DATA_W  port 1 read data (updated on reads only)
- mem_add  out  ADDR_W  to memoria add
- mem_en  out  1  to memoria en (write enable)
- mem_data_in  out  DATA_W  to memoria data_in
- mem_data_out  in  DATA_W  from memoria data_out

Behaviour:
- Memoria is taken as write-on-edge when en=1, with data_out registered one edge after add is presented.
- Reset (async, immediate): state=IDLE; ack0, ack1, mem_en = 0; rdata0, rdata1, mem_add, mem_data_in = 0; rr_last=1, so port 0 wins the first tie.
- States: IDLE, ISSUE, CAPTURE.
- IDLE:
  - A port's request is eligible when req is high and that port's ack is not high in the current cycle (masks the stale req during its own ack cycle).
  - No eligible request: stay in IDLE.
  - One eligible request: grant it.
  - Both eligible: grant the port != rr_last.
  - On the grant edge: latch sel, add, we (port 0 forces we=0) and wdata; update rr_last=sel; go to ISSUE.
- ISSUE (1 cycle):
  - mem_add = latched add; mem_data_in = latched wdata; mem_en = latched we.
  - Go to CAPTURE.
- CAPTURE (1 cycle):
  - mem_en=0; mem_add held.
  - On the edge: ack_sel <= 1; if read, rdata_sel <= mem_data_out; go to IDLE.
- ackN is high for exactly the one IDLE cycle after CAPTURE, then returns to 0.
- Latency: req sampled at edge E0 -> ack high E2..E3. Throughput is one transaction per 3 cycles.
- Outside ISSUE, mem_en=0. mem_add and mem_data_in hold their last values.
- A write returns ack1 with rdata1 unchanged.
- Back-to-back: if the acked port keeps req high, it is re-eligible in the IDLE cycle after its ack cycle. The other port wins immediately if it is pending (its req is not masked).
- Request dropped before ack (protocol violation): the latched transaction still completes and still acks.
- Reset mid-ISSUE aborts the write (mem_en drops at once). The pending transaction is discarded with no ack.
- Address wraps naturally within ADDR_W. No bounds checking.

Optional Feature:
- Macro: ARB_FIXED_PRIO_EN.
- Defined: fixed priority, port 1 (data) always wins a tie; rr_last is not implemented.
- Undefined: round-robin as described above.

Test Plan:
- Reset then idle: ack0=ack1=mem_en=0, rdata0=rdata1=0 for 10 cycles with no req.
- Port 1 write: req1=1, we1=1, add1=23, wdata1=20 -> mem_en=1 for exactly one cycle with mem_add=23, mem_data_in=20; ack1 pulses 3 edges after the request edge; rdata1 stays 0.
- Port 0 read after that write: req0=1, add0=23 -> ack0 one-cycle pulse with rdata0=20; mem_en stays 0 throughout.
- Simultaneous req0 (add 5) and req1 (read, add 6), both held: service order port 0 then port 1, no cycle gaps beyond the 3-cycle cadence; each ack pulses exactly once. Repeat with ARB_FIXED_PRIO_EN defined -> port 1 first.
- Continuous req0 with req1 raised mid-transaction: port 1 is granted at the next IDLE, so port 0 is not serviced twice in a row while req1 is pending.
- Assert rst during ISSUE of a port 1 write to add 7: mem_en falls immediately, no ack1, FSM in IDLE after release; a later port 0 read of add 7 returns the pre-write value.

Source files
------------

// File: rtl/arbitro_memoria_if.sv
// Bus bundle between the two requesters, the memory arbiter and memoria.
// The slave modport is the arbiter's view; the master modport is everything around it.
interface arbitro_memoria_if #(
   parameter int ADDR_W = 5,
   parameter int DATA_W = 14
);
   logic              req0;
   logic [ADDR_W-1:0] add0;
   logic              ack0;
   logic [DATA_W-1:0] rdata0;
   logic              req1;
   logic              we1;
   logic [ADDR_W-1:0] add1;
   logic [DATA_W-1:0] wdata1;
   logic              ack1;
   logic [DATA_W-1:0] rdata1;
   logic [ADDR_W-1:0] mem_add;
   logic              mem_en;
   logic [DATA_W-1:0] mem_data_in;
   logic [DATA_W-1:0] mem_data_out;

   modport slave (
      input  req0, add0, req1, we1, add1, wdata1, mem_data_out,
      output ack0, rdata0, ack1, rdata1, mem_add, mem_en, mem_data_in
   );

   modport master (
      output req0, add0, req1, we1, add1, wdata1, mem_data_out,
      input  ack0, rdata0, ack1, rdata1, mem_add, mem_en, mem_data_in
   );
endinterface

// File: rtl/arbitro_memoria.sv
// Two-port arbiter for the single-port memoria: IDLE -> ISSUE -> CAPTURE per access.
// Define ARB_FIXED_PRIO_EN to make port 1 win every tie instead of round-robin.
module arbitro_memoria #(
   parameter int ADDR_W = 5,
   parameter int DATA_W = 14
) (
   input logic clk,
   input logic rst,
   arbitro_memoria_if.slave bus
);

   typedef enum logic [1:0] {
      IDLE,
      ISSUE,
      CAPTURE
   } state_t;

   state_t state, state_next;

   logic              sel_q;
   logic              we_q;
   logic              ack0_q;
   logic              ack1_q;
   logic [DATA_W-1:0] rdata0_q;
   logic [DATA_W-1:0] rdata1_q;
   logic [ADDR_W-1:0] mem_add_q;
   logic              mem_en_q;
   logic [DATA_W-1:0] mem_data_in_q;

   logic elig0;
   logic elig1;
   logic grant;
   logic grant_sel;

`ifndef ARB_FIXED_PRIO_EN
   logic rr_last;
`endif

   // A port is masked during its own ack cycle, since its req is still the old one.
   assign elig0 = bus.req0 & ~ack0_q;
   assign elig1 = bus.req1 & ~ack1_q;

   assign bus.ack0        = ack0_q;
   assign bus.ack1        = ack1_q;
   assign bus.rdata0      = rdata0_q;
   assign bus.rdata1      = rdata1_q;
   assign bus.mem_add     = mem_add_q;
   assign bus.mem_en      = mem_en_q;
   assign bus.mem_data_in = mem_data_in_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   always_comb begin
      state_next = state;
      grant      = 1'b0;
      grant_sel  = 1'b0;
      case (state)
         IDLE: begin
            if (elig0 || elig1) begin
               grant      = 1'b1;
               state_next = ISSUE;
               if (elig0 && elig1) begin
`ifdef ARB_FIXED_PRIO_EN
                  grant_sel = 1'b1;
`else
                  grant_sel = ~rr_last;
`endif
               end else begin
                  grant_sel = elig1;
               end
            end
         end
         ISSUE:   state_next = CAPTURE;
         CAPTURE: state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // Memory pins are registered on the grant edge so they are valid for the whole ISSUE cycle.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sel_q         <= 1'b0;
         we_q          <= 1'b0;
         ack0_q        <= 1'b0;
         ack1_q        <= 1'b0;
         rdata0_q      <= '0;
         rdata1_q      <= '0;
         mem_add_q     <= '0;
         mem_en_q      <= 1'b0;
         mem_data_in_q <= '0;
`ifndef ARB_FIXED_PRIO_EN
         rr_last       <= 1'b1;
`endif
      end else begin
         ack0_q   <= 1'b0;
         ack1_q   <= 1'b0;
         mem_en_q <= 1'b0;
         case (state)
            IDLE: begin
               if (grant) begin
                  sel_q    <= grant_sel;
                  we_q     <= grant_sel & bus.we1;
                  mem_en_q <= grant_sel & bus.we1;
`ifndef ARB_FIXED_PRIO_EN
                  rr_last  <= grant_sel;
`endif
                  if (grant_sel) begin
                     mem_add_q     <= bus.add1;
                     mem_data_in_q <= bus.wdata1;
                  end else begin
                     mem_add_q     <= bus.add0;
                  end
               end
            end
            CAPTURE: begin
               if (sel_q) begin
                  ack1_q <= 1'b1;
                  if (!we_q) begin
                     rdata1_q <= bus.mem_data_out;
                  end
               end else begin
                  ack0_q   <= 1'b1;
                  rdata0_q <= bus.mem_data_out;
               end
            end
            default: begin
            end
         endcase
      end
   end

endmodule

// File: tb/tb_arbitro_memoria.sv
// Scoreboard bench for arbitro_memoria with a behavioural memoria model.
// Expected acks and memory writes are queued by the stimulus and popped by a monitor.
module tb_arbitro_memoria;

   localparam int ADDR_W = 5;
   localparam int DATA_W = 14;

   typedef struct {
      bit                port;
      logic [DATA_W-1:0] data;
   } ack_exp_t;

   typedef struct {
      logic [ADDR_W-1:0] add;
      logic [DATA_W-1:0] data;
   } wr_exp_t;

   logic clk;
   logic rst;
   int   checks;
   int   errors;

   ack_exp_t ack_q[$];
   wr_exp_t  wr_q[$];

   logic [DATA_W-1:0] mem [32];

   arbitro_memoria_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

   arbitro_memoria #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // memoria: write on the edge when en=1, registered read of the presented address
   initial begin
      for (int i = 0; i < 32; i++) mem[i] = DATA_W'(i + 100);
   end

   always @(posedge clk) begin
      if (bus.mem_en) mem[bus.mem_add] <= bus.mem_data_in;
      bus.mem_data_out <= mem[bus.mem_add];
   end

   task automatic checkOutput(input string name, input int actual, input int expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, actual, expected, $time);
      end
   endtask

   task automatic expectAck(input bit port, input logic [DATA_W-1:0] data);
      ack_exp_t e;
      e.port = port;
      e.data = data;
      ack_q.push_back(e);
   endtask

   task automatic applyStimulus(input bit port, input bit we, input logic [ADDR_W-1:0] add,
                                input logic [DATA_W-1:0] wdata, input logic [DATA_W-1:0] exp_data);
      wr_exp_t w;
      if (port) begin
         bus.req1   = 1'b1;
         bus.we1    = we;
         bus.add1   = add;
         bus.wdata1 = wdata;
         if (we) begin
            w.add  = add;
            w.data = wdata;
            wr_q.push_back(w);
         end
      end else begin
         bus.req0 = 1'b1;
         bus.add0 = add;
      end
      expectAck(port, exp_data);
   endtask

   // Counts negedges until the port's ack is seen, then drops that req.
   task automatic waitAck(input bit port, output int cycles);
      cycles = -1;
      for (int i = 1; i <= 12; i++) begin
         @(negedge clk);
         if ((port ? bus.ack1 : bus.ack0) === 1'b1) begin
            cycles = i;
            break;
         end
      end
      if (port) bus.req1 = 1'b0;
      else      bus.req0 = 1'b0;
   endtask

   task automatic doReset();
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      checkOutput("rst_acks", {bus.ack0, bus.ack1, bus.mem_en}, 0);
      checkOutput("rst_rdata", {bus.rdata0, bus.rdata1}, 0);
      checkOutput("rst_mem_add", bus.mem_add, 0);
      checkOutput("rst_mem_data_in", bus.mem_data_in, 0);
      rst = 1'b0;
   endtask

   always @(negedge clk) begin
      if (!rst) begin
         if (bus.ack0 || bus.ack1) begin
            if (bus.ack0 && bus.ack1) begin
               checkOutput("ack_both", 1, 0);
            end else if (ack_q.size() == 0) begin
               checkOutput("ack_unexpected", bus.ack1 ? 1 : 0, -1);
            end else begin
               ack_exp_t e;
               e = ack_q.pop_front();
               checkOutput("ack_port", bus.ack1 ? 1 : 0, e.port ? 1 : 0);
               checkOutput("ack_rdata", bus.ack1 ? bus.rdata1 : bus.rdata0, e.data);
            end
         end
         if (bus.mem_en) begin
            if (wr_q.size() == 0) begin
               checkOutput("wr_unexpected", bus.mem_add, -1);
            end else begin
               wr_exp_t w;
               w = wr_q.pop_front();
               checkOutput("wr_add", bus.mem_add, w.add);
               checkOutput("wr_data", bus.mem_data_in, w.data);
            end
         end
      end
   end

   initial begin
      int c0;
      int c1;
      int c0b;
      int cnt;
      checks     = 0;
      errors     = 0;
      rst        = 1'b1;
      bus.req0   = 1'b0;
      bus.add0   = '0;
      bus.req1   = 1'b0;
      bus.we1    = 1'b0;
      bus.add1   = '0;
      bus.wdata1 = '0;
      repeat (2) @(negedge clk);
      rst = 1'b0;

      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         checkOutput("idle", {bus.ack0, bus.ack1, bus.mem_en, bus.rdata0, bus.rdata1}, 0);
      end

      $display("[TB] port 1 write add 23 data 20");
      applyStimulus(1'b1, 1'b1, 5'd23, 14'd20, 14'd0);
      waitAck(1'b1, c1);
      checkOutput("wr_latency", c1, 3);
      checkOutput("wr_rdata1_kept", bus.rdata1, 0);

      $display("[TB] port 0 read add 23");
      applyStimulus(1'b0, 1'b0, 5'd23, 14'd0, 14'd20);
      waitAck(1'b0, c0);
      checkOutput("rd_latency", c0, 3);
      @(negedge clk);
      checkOutput("ack0_pulse", bus.ack0, 0);
      checkOutput("rdata0_held", bus.rdata0, 20);

      $display("[TB] tie between port 0 add 5 and port 1 read add 6");
      doReset();
      c0 = -1;
      c1 = -1;
`ifdef ARB_FIXED_PRIO_EN
      applyStimulus(1'b1, 1'b0, 5'd6, 14'd0, 14'd106);
      applyStimulus(1'b0, 1'b0, 5'd5, 14'd0, 14'd105);
`else
      applyStimulus(1'b0, 1'b0, 5'd5, 14'd0, 14'd105);
      applyStimulus(1'b1, 1'b0, 5'd6, 14'd0, 14'd106);
`endif
      for (int i = 1; i <= 15 && (c0 < 0 || c1 < 0); i++) begin
         @(negedge clk);
         if (bus.ack0 === 1'b1) begin
            c0 = i;
            bus.req0 = 1'b0;
         end
         if (bus.ack1 === 1'b1) begin
            c1 = i;
            bus.req1 = 1'b0;
         end
      end
      bus.req0 = 1'b0;
      bus.req1 = 1'b0;
`ifdef ARB_FIXED_PRIO_EN
      checkOutput("tie_first_p1", c1, 3);
      checkOutput("tie_second_p0", c0, 6);
`else
      checkOutput("tie_first_p0", c0, 3);
      checkOutput("tie_second_p1", c1, 6);
`endif

      $display("[TB] continuous port 0, port 1 raised mid-transaction");
      c0  = -1;
      c0b = -1;
      c1  = -1;
      cnt = 0;
      applyStimulus(1'b0, 1'b0, 5'd5, 14'd0, 14'd105);
      for (int i = 1; i <= 15 && c0b < 0; i++) begin
         @(negedge clk);
         if (i == 1) begin
            applyStimulus(1'b1, 1'b0, 5'd6, 14'd0, 14'd106);
            expectAck(1'b0, 14'd105);
         end
         if (bus.ack1 === 1'b1) begin
            c1 = i;
            bus.req1 = 1'b0;
         end
         if (bus.ack0 === 1'b1) begin
            cnt++;
            if (cnt == 1) c0 = i;
            else begin
               c0b = i;
               bus.req0 = 1'b0;
            end
         end
      end
      bus.req0 = 1'b0;
      bus.req1 = 1'b0;
      checkOutput("cont_p0_first", c0, 3);
      checkOutput("cont_p1_next", c1, 6);
      checkOutput("cont_p0_again", c0b, 9);

      $display("[TB] reset during ISSUE of port 1 write to add 7");
      @(negedge clk);
      bus.req1   = 1'b1;
      bus.we1    = 1'b1;
      bus.add1   = 5'd7;
      bus.wdata1 = 14'd999;
      @(posedge clk);
      #2;
      checkOutput("abort_en_before", bus.mem_en, 1);
      rst = 1'b1;
      #1;
      checkOutput("abort_en_drop", bus.mem_en, 0);
      bus.req1 = 1'b0;
      bus.we1  = 1'b0;
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         checkOutput("abort_quiet", {bus.ack0, bus.ack1, bus.mem_en}, 0);
      end
      applyStimulus(1'b0, 1'b0, 5'd7, 14'd0, 14'd107);
      waitAck(1'b0, c0);
      checkOutput("abort_read_latency", c0, 3);

      repeat (3) @(negedge clk);
      checkOutput("ack_q_drained", ack_q.size(), 0);
      checkOutput("wr_q_drained", wr_q.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: got timeout expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

endmodule
